// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - read-stage issue/hazard bundle between decode, memory and the hazard controller
interface hazard_ctrl_if;

  // Instruction presented by decode to the read stage
  logic        issue_valid;
  logic        read_a;
  logic [3:0]  arg_a;
  logic        read_b;
  logic [3:0]  arg_b;
  logic [3:0]  dst;
  logic        mem_en;
  logic        mem_write;
  logic        br_taken;

  // Load data return from memory
  logic        mem_ack;
  logic [3:0]  mem_ack_dst;

  // Halt/drain request from the debug/control side
  logic        halt_req;

  // Controller responses
  logic        issue;
  logic        stall;
  logic        flush;
  logic [15:0] pending;
  logic [3:0]  outstanding;
  logic        halted;
  logic        sb_err;

  // Pipeline side: drives the instruction, acks and halt request
  modport master (
    output issue_valid, read_a, arg_a, read_b, arg_b, dst,
           mem_en, mem_write, br_taken, mem_ack, mem_ack_dst, halt_req,
    input  issue, stall, flush, pending, outstanding, halted, sb_err
  );

  // Controller side
  modport slave (
    input  issue_valid, read_a, arg_a, read_b, arg_b, dst,
           mem_en, mem_write, br_taken, mem_ack, mem_ack_dst, halt_req,
    output issue, stall, flush, pending, outstanding, halted, sb_err
  );

endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load scoreboard, issue stall, branch-shadow flush and halt/drain sequencing
module hazard_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  hazard_ctrl_if.slave hc
);

  localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Control state
  state_t      state_q,     state_d;
  logic        flush_q,     flush_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        halted_q,    halted_d;

  // Scoreboard state
  logic [15:0] pending_q,     pending_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        sb_err_q,      sb_err_d;

  // Decoded instruction and hazard terms
  logic        is_load;
  logic        src_a_hit;
  logic        src_b_hit;
  logic        waw_hit;
  logic        full_hit;
  logic        hazard;
  logic        stall;
  logic        issue;
  logic        load_issue;

  // Ack classification and scoreboard update masks
  logic        ack_hit;
  logic        ack_miss;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;

  assign is_load = hc.mem_en & ~hc.mem_write;

  // Hazards look only at registered scoreboard state, so a same-cycle ack
  // still costs one bubble; this keeps the ack path out of the stall path.
  assign src_a_hit = hc.read_a & pending_q[hc.arg_a];
  assign src_b_hit = hc.read_b & pending_q[hc.arg_b];
  assign waw_hit   = is_load & pending_q[hc.dst];
  assign full_hit  = is_load & (outstanding_q == MAX_CNT);
  assign hazard    = src_a_hit | src_b_hit | waw_hit | full_hit;

  // Anything other than RUN, or a pending halt request, holds the read stage.
  assign stall      = hc.issue_valid & (hazard | (state_q != ST_RUN) | hc.halt_req);
  assign issue      = hc.issue_valid & ~stall;
  assign load_issue = issue & is_load;

  // An ack is only honoured if its register is actually tracked; anything
  // else is a protocol error from the memory side.
  assign ack_hit  = hc.mem_ack &  pending_q[hc.mem_ack_dst];
  assign ack_miss = hc.mem_ack & ~pending_q[hc.mem_ack_dst];

  assign set_mask = load_issue ? (16'h0001 << hc.dst)         : 16'h0000;
  assign clr_mask = ack_hit    ? (16'h0001 << hc.mem_ack_dst) : 16'h0000;

  // Scoreboard next state: set on load issue, clear on matching ack, count in-flight loads
  always_comb begin
    pending_d     = (pending_q | set_mask) & ~clr_mask;
    outstanding_d = outstanding_q;
    sb_err_d      = sb_err_q | ack_miss;
    case ({load_issue, ack_hit})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Scoreboard registers; reset drops all in-flight tracking and ignores same-cycle acks
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pending_q     <= 16'h0000;
      outstanding_q <= 4'd0;
      sb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      sb_err_q      <= sb_err_d;
    end
  end

  // Control FSM next state: branch-shadow flush countdown and halt/drain handshake
  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        // halt_req already blocks issue, so a taken branch and a halt
        // request can never both be acted on in the same cycle.
        if (issue & hc.br_taken) begin
          state_d     = ST_FLUSH;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
        end else if (hc.halt_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        // The shadow is always squashed in full; a halt request waiting
        // here is picked up only once the flush window closes.
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          flush_d     = 1'b0;
          flush_cnt_d = 3'd0;
          state_d     = hc.halt_req ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Using the next-state count lets the final ack and the halt land
        // on the same edge.
        if (!hc.halt_req) begin
          state_d = ST_RUN;
        end else if (outstanding_d == 4'd0) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!hc.halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_d     = 1'b0;
        flush_cnt_d = 3'd0;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  // Control FSM registers
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_RUN;
      flush_q     <= 1'b0;
      flush_cnt_q <= 3'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      flush_cnt_q <= flush_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign hc.issue       = issue;
  assign hc.stall       = stall;
  assign hc.flush       = flush_q;
  assign hc.pending     = pending_q;
  assign hc.outstanding = outstanding_q;
  assign hc.halted      = halted_q;
  assign hc.sb_err      = sb_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector table plus randomized model comparison for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MAXO = 4;
  localparam int FC   = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_ctrl_if hc_if ();

  hazard_ctrl #(
    .MAX_OUTSTANDING(MAXO),
    .FLUSH_CYCLES   (FC)
  ) u_dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .hc     (hc_if)
  );

  typedef struct {
    logic        rst, iv, ra;
    logic [3:0]  a;
    logic        rb;
    logic [3:0]  b, dst;
    logic        men, mwr, br, ack;
    logic [3:0]  ackd;
    logic        halt;
    logic        e_issue, e_stall, e_flush;
    logic [15:0] e_pend;
    logic [3:0]  e_out;
    logic        e_halted, e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: pending loads as a register set, in-flight count derived
  // from the set size, and the control mode kept as plain counters/flags.
  logic [15:0] m_pend;
  bit          m_err;
  int          m_flush_left;
  bit          m_drain;
  bit          m_halted;
  bit          m_issue, m_stall;

  function automatic vec_t mk(input int rst, iv, ra, a, rb, b, dst, men, mwr, br, ack, ackd, halt,
                              ei, es, ef, ep, eo, eh, ee);
    vec_t v;
    v.rst = 1'(rst); v.iv = 1'(iv); v.ra = 1'(ra); v.a = 4'(a); v.rb = 1'(rb); v.b = 4'(b);
    v.dst = 4'(dst); v.men = 1'(men); v.mwr = 1'(mwr); v.br = 1'(br); v.ack = 1'(ack);
    v.ackd = 4'(ackd); v.halt = 1'(halt);
    v.e_issue = 1'(ei); v.e_stall = 1'(es); v.e_flush = 1'(ef); v.e_pend = 16'(ep);
    v.e_out = 4'(eo); v.e_halted = 1'(eh); v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 16'h0; m_err = 0; m_flush_left = 0; m_drain = 0; m_halted = 0;
  endtask

  task automatic model_comb(input vec_t v);
    bit ld, haz, running;
    ld      = v.men && !v.mwr;
    running = (m_flush_left == 0) && !m_drain && !m_halted;
    haz     = (v.ra && m_pend[v.a]) || (v.rb && m_pend[v.b]) || (ld && m_pend[v.dst]) ||
              (ld && ($countones(m_pend) == MAXO));
    m_stall = v.iv && (haz || !running || v.halt);
    m_issue = v.iv && !m_stall;
  endtask

  task automatic model_step(input vec_t v);
    logic [15:0] np;
    bit          ld;
    if (v.rst) begin
      model_reset();
      return;
    end
    ld = v.men && !v.mwr;
    np = m_pend;
    if (v.ack) begin
      if (m_pend[v.ackd]) np[v.ackd] = 1'b0;
      else m_err = 1;
    end
    if (m_issue && ld) np[v.dst] = 1'b1;
    if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0 && v.halt) m_drain = 1;
    end else if (m_drain) begin
      if (!v.halt) m_drain = 0;
      else if ($countones(np) == 0) begin m_drain = 0; m_halted = 1; end
    end else if (m_halted) begin
      if (!v.halt) m_halted = 0;
    end else if (m_issue && v.br) begin
      m_flush_left = FC;
    end else if (v.halt) begin
      m_drain = 1;
    end
    m_pend = np;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // mode 0: no check, 1: check against table record, 2: check against model
  task automatic run(input vec_t v, input int mode, input int idx);
    vec_t e;
    rst                 = v.rst;
    hc_if.issue_valid   = v.iv;
    hc_if.read_a        = v.ra;
    hc_if.arg_a         = v.a;
    hc_if.read_b        = v.rb;
    hc_if.arg_b         = v.b;
    hc_if.dst           = v.dst;
    hc_if.mem_en        = v.men;
    hc_if.mem_write     = v.mwr;
    hc_if.br_taken      = v.br;
    hc_if.mem_ack       = v.ack;
    hc_if.mem_ack_dst   = v.ackd;
    hc_if.halt_req      = v.halt;
    #1;
    model_comb(v);
    if (mode == 1) begin
      e = v;
    end else begin
      e = v;
      e.e_issue = m_issue; e.e_stall = m_stall; e.e_flush = (m_flush_left > 0);
      e.e_pend = m_pend; e.e_out = 4'($countones(m_pend)); e.e_halted = m_halted; e.e_err = m_err;
    end
    if (mode != 0) begin
      chk("issue",       idx, 32'(hc_if.issue),       32'(e.e_issue));
      chk("stall",       idx, 32'(hc_if.stall),       32'(e.e_stall));
      chk("flush",       idx, 32'(hc_if.flush),       32'(e.e_flush));
      chk("pending",     idx, 32'(hc_if.pending),     32'(e.e_pend));
      chk("outstanding", idx, 32'(hc_if.outstanding), 32'(e.e_out));
      chk("halted",      idx, 32'(hc_if.halted),      32'(e.e_halted));
      chk("sb_err",      idx, 32'(hc_if.sb_err),      32'(e.e_err));
    end
    @(posedge clk);
    model_step(v);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   q[$];
    bit   halt_r;

    //           rst iv ra a rb b dst men mwr br ack ackd halt | iss stl fl pend out hl err
    // Reset state, load-use with a same-cycle ack bubble
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,0,0,0, 0,1,0,'h0020,1,0,0));
    tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,0,0,0, 0,1,0,'h0020,1,0,0));
    tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,1,5,0, 0,1,0,'h0020,1,0,0));
    tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    // Capacity: four loads fill the window, fifth waits one cycle past the ack
    tbl.push_back(mk(0,1,0,0,0,0,1,1,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,2,1,0,0,0,0,0, 1,0,0,'h0002,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,0,0,0, 1,0,0,'h0006,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,4,1,0,0,0,0,0, 1,0,0,'h000E,3,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,6,1,0,0,0,0,0, 0,1,0,'h001E,4,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,6,1,0,0,1,2,0, 0,1,0,'h001E,4,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,6,1,0,0,0,0,0, 1,0,0,'h001A,3,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h005A,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,0,'h005A,4,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,3,0, 0,0,0,'h0058,3,0,0));
    // Simultaneous load issue and ack keep the count steady
    tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,1,4,0, 1,0,0,'h0050,2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,7,1,0,0,1,3,0, 1,0,0,'h0048,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h00C0,2,0,0));
    // WAW on r6, read_b hazard on r7, then retire both
    tbl.push_back(mk(0,1,0,0,0,0,6,1,0,0,0,0,0, 0,1,0,'h00C0,2,0,0));
    tbl.push_back(mk(0,1,0,0,1,7,0,0,0,0,0,0,0, 0,1,0,'h00C0,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,6,0, 0,0,0,'h00C0,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,7,0, 0,0,0,'h0080,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));
    // Taken branch: two flush cycles; br_taken without issue_valid ignored
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 0,1,1,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 0,1,1,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));
    // Halt with two loads in flight, acks at t+3 and t+5
    tbl.push_back(mk(0,1,0,0,0,0,1,1,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,2,1,0,0,0,0,0, 1,0,0,'h0002,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,'h0006,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0006,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0006,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,1, 0,0,0,'h0006,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0004,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,2,1, 0,0,0,'h0004,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,1, 0,1,0,'h0000,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,'h0000,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    // Halt raised during a flush waits for the flush, then drains to HALTED
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,1,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,1,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0000,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));
    // Spurious ack, then reset mid-flush with r1/r5 pending and an ack in the reset cycle
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,9,0, 0,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,1,1,0,0,0,0,0, 1,0,0,'h0000,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,5,1,0,0,0,0,0, 1,0,0,'h0002,1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,1,0,0,0, 1,0,0,'h0022,2,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1,'h0022,2,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1,'h0022,2,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,0,0,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    // Halt withdrawn mid-drain: back to RUN, the load still retires
    tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,0,0,0, 1,0,0,'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0008,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,'h0008,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,'h0008,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h0008,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,3,0, 0,0,0,'h0008,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,'h0000,0,0,0));

    model_reset();
    v = mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    run(v, 0, -1);
    run(v, 0, -1);

    foreach (tbl[i]) run(tbl[i], 1, i);

    run(v, 0, -1);
    halt_r = 0;
    for (int n = 0; n < 1500; n++) begin
      v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      v.rst = ($urandom_range(0, 299) == 0);
      v.iv  = ($urandom_range(0, 3) != 0);
      v.ra  = 1'($urandom_range(0, 1));
      v.rb  = 1'($urandom_range(0, 1));
      v.a   = 4'($urandom_range(0, 7));
      v.b   = 4'($urandom_range(0, 7));
      v.dst = 4'($urandom_range(0, 7));
      v.men = 1'($urandom_range(0, 1));
      v.mwr = ($urandom_range(0, 3) == 0);
      v.br  = ($urandom_range(0, 7) == 0);
      v.ack = ($urandom_range(0, 2) == 0);
      q.delete();
      for (int r = 0; r < 16; r++) if (m_pend[r]) q.push_back(r);
      if (q.size() != 0 && $urandom_range(0, 15) != 0)
        v.ackd = 4'(q[$urandom_range(0, q.size() - 1)]);
      else
        v.ackd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) halt_r = !halt_r;
      v.halt = halt_r;
      run(v, 2, 1000 + n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and issue controller for the register-read stage. It keeps a scoreboard of registers with loads in flight, counts outstanding memory reads, and stalls issue on load-use and write-after-write hazards. It also flushes the branch shadow after a taken PC redirect and sequences a halt/drain handshake. ALU results reach the read stage through exe/wb forwarding, so only memory loads are scoreboarded.

Parameters:
MAX_OUTSTANDING, 4, maximum loads in flight (1..15)
FLUSH_CYCLES, 2, cycles of flush asserted after a taken redirect (1..7)

Ports:
cpu_clk  in  1  clock; all state updates on rising edge
cpu_rst  in  1  synchronous reset, active-high
issue_valid  in  1  decode presents an instruction to the read stage
read_a  in  1  instruction reads register arg_a
arg_a  in  4  source register A
read_b  in  1  instruction reads register arg_b
arg_b  in  4  source register B
dst  in  4  destination register
mem_en  in  1  instruction performs a memory access
mem_write  in  1  the access is a store (0 = load, writes dst)
br_taken  in  1  resolved redirect (pc_set or pc_add taken) for the presented instruction
mem_ack  in  1  memory returns load data this cycle
mem_ack_dst  in  4  destination register of the returning load
halt_req  in  1  request to stop issue and drain memory
issue  out  1  instruction advances this cycle (combinational)
stall  out  1  hold the read stage (combinational)
flush  out  1  squash the instruction in the read stage (registered)
pending  out  16  scoreboard; bit r = load to register r in flight
outstanding  out  4  count of loads in flight
halted  out  1  pipeline drained and stopped
sb_err  out  1  sticky: spurious or unmatched mem_ack

Behaviour:
- Reset values: state=RUN; pending=0; outstanding=0; flush=0; flush counter=0; halted=0; sb_err=0. Reset applied mid-operation discards all in-flight tracking. Acks in the same cycle as reset are ignored.
- States: RUN, FLUSH, DRAIN, HALTED (2-bit encoding).
- is_load = mem_en & ~mem_write.
- hazard = (read_a & pending[arg_a]) | (read_b & pending[arg_b]) | (is_load & pending[dst]) | (is_load & outstanding==MAX_OUTSTANDING).
- hazard uses the registered pending bits. An ack in the same cycle does not clear the hazard until the next cycle (1-cycle bubble).
- stall = issue_valid & (hazard | state!=RUN | halt_req).
- issue = issue_valid & ~stall. Only RUN can issue.
- Scoreboard set: issue & is_load sets pending[dst].
- Scoreboard clear: mem_ack with pending[mem_ack_dst]=1 clears that bit.
- Set and clear of the same register in one cycle cannot occur, because the WAW hazard blocks it.
- outstanding: +1 on a load issue, -1 on a valid ack, unchanged when both occur in the same cycle.
- Invalid ack (mem_ack with pending[mem_ack_dst]=0) sets sb_err. pending and outstanding are unchanged. sb_err clears only on reset.
- RUN -> FLUSH when issue & br_taken. The flush counter loads FLUSH_CYCLES, and flush=1 from the next cycle.
- br_taken without issue is ignored.
- FLUSH: counter decrements each cycle while flush=1. When counter==1, flush drops on the next edge.
  - If halt_req=1 at that point, go to DRAIN; otherwise go to RUN.
  - halt_req does not shorten the flush.
- RUN -> DRAIN when halt_req=1 and no issue-with-branch occurs; halt_req already blocks issue combinationally.
- DRAIN -> HALTED when outstanding==0 at the clock edge, counting any same-cycle decrement (outstanding==1 with a valid ack also qualifies).
- DRAIN -> RUN when halt_req drops before drain completes. Pending loads continue to retire normally.
- HALTED: halted=1 (registered with the state). HALTED -> RUN when halt_req=0, with halted=0 on the same edge.
- Acks are processed in every state.
- Latency:
  - stall and issue respond combinationally to inputs and registered state.
  - flush rises 1 cycle after the taken issue and lasts exactly FLUSH_CYCLES cycles.
  - halted rises 1 cycle after the cycle in which outstanding reaches 0 during DRAIN.

Test Plan:
- Load-use: issue load dst=5, then next instruction read_a=1 arg_a=5 -> stall=1, pending[5]=1, outstanding=1. mem_ack dst=5 at cycle 4 -> stall still 1 that cycle, issue=1 at cycle 5, pending=0.
- Capacity: 4 loads to r1..r4 back-to-back with no acks, 5th load to r6 -> issue=0, outstanding=4. A single ack for r2 plus a same-cycle 5th load still stalls (registered count); it issues next cycle with outstanding=4.
- Simultaneous: load to r7 issues while ack for r3 arrives -> outstanding unchanged (2 -> 2), pending[3]=0, pending[7]=1.
- Branch: issue with br_taken=1, FLUSH_CYCLES=2 -> flush=1 for exactly cycles t+1 and t+2, issue=0 during both, RUN at t+3. br_taken with issue_valid=0 -> no flush.
- Halt: outstanding=2, assert halt_req -> stall=1 immediately. Acks at t+3 and t+5 -> halted=1 at t+6. Drop halt_req -> halted=0 and issue possible the next cycle.
- Error and reset: mem_ack dst=9 with pending=0 -> sb_err=1, outstanding stays 0. Assert cpu_rst mid-FLUSH with pending=0x0022 -> next cycle all outputs at reset values, sb_err=0.
